// File: rtl/sc_host_ctrl_if.sv
// rtl/sc_host_ctrl_if.sv - host request/response bus and counter-array command bus
// host: master = requesting host, slave = sc_host_ctrl; array: master = sc_host_ctrl, slave = counter array

interface sc_host_req_if #(
    parameter int N = 10,
    parameter int W = 64
);
    localparam int IW = $clog2(N);

    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [IW-1:0] req_id;
    logic [31:0]   req_size;
    logic [W-1:0]  req_data;
    logic          rsp_valid;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;

    modport master (
        output req_valid, req_op, req_id, req_size, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_id, req_size, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

interface sc_cnt_array_if #(
    parameter int N = 10,
    parameter int G = 4,
    parameter int W = 64
);
    localparam int IW = $clog2(N);

    logic [2:0]    command_in;
    logic [IW-1:0] id;
    logic [31:0]   new_counter_size;
    logic [W-1:0]  load_data_in;
    logic          valid_load_data;
    logic [IW:0]   allocation_id;
    logic          valid_allocation_id;
    logic [G-1:0]  rdata_out;
    logic          valid_data_out;
    logic          last;

    modport master (
        output command_in, id, new_counter_size, load_data_in, valid_load_data,
        input  allocation_id, valid_allocation_id, rdata_out, valid_data_out, last
    );

    modport slave (
        input  command_in, id, new_counter_size, load_data_in, valid_load_data,
        output allocation_id, valid_allocation_id, rdata_out, valid_data_out, last
    );
endinterface

// File: rtl/sc_host_ctrl.sv
// rtl/sc_host_ctrl.sv - sequences host requests onto the shared counter array
// Optional feature macro: SC_HOST_TIMEOUT_EN bounds WAIT_ALLOC/READ to TIMEOUT idle cycles.

module sc_host_ctrl #(
    parameter int N       = 10,
    parameter int G       = 4,
    parameter int W       = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    sc_host_req_if.slave   host,
    sc_cnt_array_if.master arr
);
    localparam int BEATS = W / G;
    localparam int CW    = $clog2(BEATS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ALLOC,
        S_READ,
        S_RESP
    } state_t;

    state_t        state;
    logic [2:0]    op_q;
    logic [CW-1:0] beat_cnt;
    logic          overflow_q;
    logic [W-1:0]  asm_q;
    logic [W-1:0]  asm_next;
    logic          overflow_next;
    logic          req_ok;

`ifdef SC_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;
    logic          wait_expired;

    assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));
`endif

    always_comb begin
        req_ok = 1'b0;
        case (host.req_op)
            3'b001, 3'b010, 3'b011, 3'b100, 3'b101: req_ok = (int'(host.req_id) < N);
            default:                                req_ok = 1'b0;
        endcase
    end

    // beat_cnt saturates at BEATS, so any beat seen there is an overflow and is dropped
    always_comb begin
        asm_next      = asm_q;
        overflow_next = overflow_q || (beat_cnt == CW'(BEATS));
        for (int k = 0; k < BEATS; k++) begin
            if (int'(beat_cnt) == k) begin
                asm_next[k*G +: G] = arr.rdata_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= S_IDLE;
            op_q                 <= 3'b000;
            beat_cnt             <= '0;
            overflow_q           <= 1'b0;
            asm_q                <= '0;
            host.req_ready       <= 1'b1;
            host.rsp_valid       <= 1'b0;
            host.rsp_data        <= '0;
            host.rsp_err         <= 1'b0;
            arr.command_in       <= 3'b000;
            arr.id               <= '0;
            arr.new_counter_size <= '0;
            arr.load_data_in     <= '0;
            arr.valid_load_data  <= 1'b0;
`ifdef SC_HOST_TIMEOUT_EN
            wait_cnt             <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (host.req_valid && host.req_ready) begin
                        host.req_ready <= 1'b0;
                        op_q           <= host.req_op;
                        beat_cnt       <= '0;
                        overflow_q     <= 1'b0;
                        asm_q          <= '0;
`ifdef SC_HOST_TIMEOUT_EN
                        wait_cnt       <= '0;
`endif
                        if (req_ok) begin
                            state                <= S_ISSUE;
                            arr.command_in       <= host.req_op;
                            arr.id               <= host.req_id;
                            arr.new_counter_size <= host.req_size;
                            arr.load_data_in     <= host.req_data;
                            arr.valid_load_data  <= (host.req_op == 3'b100);
                        end else begin
                            state          <= S_RESP;
                            host.rsp_valid <= 1'b1;
                            host.rsp_err   <= 1'b1;
                            host.rsp_data  <= '0;
                        end
                    end
                end

                S_ISSUE: begin
                    arr.new_counter_size <= '0;
                    arr.load_data_in     <= '0;
                    arr.valid_load_data  <= 1'b0;
                    case (op_q)
                        3'b010: begin
                            arr.command_in <= 3'b000;
                            arr.id         <= '0;
                            state          <= S_WAIT_ALLOC;
                        end
                        // a read keeps command_in/id on the bus for the whole stream
                        3'b101: state <= S_READ;
                        default: begin
                            arr.command_in <= 3'b000;
                            arr.id         <= '0;
                            state          <= S_RESP;
                            host.rsp_valid <= 1'b1;
                            host.rsp_err   <= 1'b0;
                            host.rsp_data  <= '0;
                        end
                    endcase
                end

                S_WAIT_ALLOC: begin
                    if (arr.valid_allocation_id) begin
                        state          <= S_RESP;
                        host.rsp_valid <= 1'b1;
                        host.rsp_err   <= 1'b0;
                        host.rsp_data  <= W'(arr.allocation_id);
                    end
`ifdef SC_HOST_TIMEOUT_EN
                    else if (wait_expired) begin
                        state          <= S_RESP;
                        host.rsp_valid <= 1'b1;
                        host.rsp_err   <= 1'b1;
                        host.rsp_data  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
`endif
                end

                S_READ: begin
                    if (arr.valid_data_out) begin
                        asm_q      <= asm_next;
                        overflow_q <= overflow_next;
                        if (beat_cnt != CW'(BEATS)) begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
`ifdef SC_HOST_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                        if (arr.last) begin
                            arr.command_in <= 3'b000;
                            arr.id         <= '0;
                            state          <= S_RESP;
                            host.rsp_valid <= 1'b1;
                            host.rsp_err   <= overflow_next;
                            host.rsp_data  <= asm_next;
                        end
                    end
`ifdef SC_HOST_TIMEOUT_EN
                    else if (wait_expired) begin
                        arr.command_in <= 3'b000;
                        arr.id         <= '0;
                        state          <= S_RESP;
                        host.rsp_valid <= 1'b1;
                        host.rsp_err   <= 1'b1;
                        host.rsp_data  <= asm_q;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
`endif
                end

                S_RESP: begin
                    state          <= S_IDLE;
                    host.req_ready <= 1'b1;
                    host.rsp_valid <= 1'b0;
                    host.rsp_err   <= 1'b0;
                    host.rsp_data  <= '0;
                end

                default: begin
                    state          <= S_IDLE;
                    host.req_ready <= 1'b1;
                    host.rsp_valid <= 1'b0;
                    arr.command_in <= 3'b000;
                end
            endcase
        end
    end

    if ((W % G) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("sc_host_ctrl: W must be a multiple of G and TIMEOUT must be positive");
    end

endmodule

// File: doc/sc_host_ctrl.md
SC_HOST_CTRL -- requirements
Module: sc_host_ctrl

Interface
REQ-001 SHALL have parameter N, default 10, number of shared counters.
REQ-002 SHALL have parameter G, default 4, read-stream chunk width.
REQ-003 SHALL have parameter W, default 64, assembled read/load word width; W multiple of G.
REQ-004 SHALL have parameter TIMEOUT, default 1024, max wait cycles for a counter-array reply.
REQ-005 SHALL have ports:
  clk  input  1  sole clock, rising edge;
  rst  input  1  asynchronous, active-low reset;
  req_valid  input  1  host request valid;
  req_ready  output  1  block accepts a request;
  req_op  input  3  001 inc, 010 new, 011 dealloc, 100 load, 101 read;
  req_id  input  $clog2(N)  target counter id;
  req_size  input  32  size for new-counter op;
  req_data  input  W  load data;
  rsp_valid  output  1  one-cycle response strobe;
  rsp_data  output  W  read word, or allocation id zero-extended for op 010;
  rsp_err  output  1  error flag, qualified by rsp_valid;
  command_in  output  3  command to counter array;
  id  output  $clog2(N)  counter id to array;
  new_counter_size  output  32  size to array;
  load_data_in  output  W  load word to array;
  valid_load_data  output  1  load qualifier;
  allocation_id  input  $clog2(N)+1  id returned by array;
  valid_allocation_id  input  1  qualifies allocation_id;
  rdata_out  input  G  read-stream chunk;
  valid_data_out  input  1  qualifies rdata_out;
  last  input  1  final chunk marker, qualified by valid_data_out.

Function
REQ-006 SHALL implement FSM IDLE, ISSUE, WAIT_ALLOC, READ, RESP; req_ready=1 only in IDLE.
REQ-007 SHALL accept a request on req_valid&&req_ready, registering op, id, size, data; IDLE->ISSUE.
REQ-008 SHALL reject op 000/110/111 or req_id>=N: no command issued, IDLE->RESP with rsp_err=1.
REQ-009 ISSUE SHALL drive command_in=req_op, id, and size/data for exactly one cycle; valid_load_data=1 only for op 100.
REQ-010 Ops 001/011/100 SHALL go ISSUE->RESP; rsp_valid asserts the cycle after the command cycle, rsp_err=0.
REQ-011 Op 010 SHALL go ISSUE->WAIT_ALLOC; first cycle with valid_allocation_id=1 latches allocation_id into rsp_data -> RESP.
REQ-012 Op 101 SHALL go ISSUE->READ and hold command_in=101 with id until the beat with last=1 is accepted.
REQ-013 READ beat k (0-based) SHALL land in bits [k*G +: G] of the assembled word (LSB-first); bits above the last beat read 0.
REQ-014 Beats beyond W/G SHALL be dropped; the overflow SHALL set rsp_err=1 at response.
REQ-015 A beat with valid_data_out=1 and last=1 SHALL be stored, then command_in=000 next cycle, READ->RESP.
REQ-016 RESP SHALL pulse rsp_valid for exactly one cycle with rsp_data/rsp_err stable in that cycle, then go to IDLE.
REQ-017 Outside ISSUE/READ, command_in SHALL be 000, valid_load_data 0, new_counter_size 0, load_data_in 0.
REQ-018 valid_allocation_id or valid_data_out arriving in any state other than WAIT_ALLOC/READ SHALL be ignored.

Reset
REQ-019 rst=0 SHALL asynchronously force IDLE with all outputs 0 except req_ready=1; counters and assembly register cleared.
REQ-020 rst asserted mid-READ or mid-WAIT_ALLOC SHALL abort without a response; after release the first cycle is IDLE.

Configuration
REQ-021 With SC_HOST_TIMEOUT_EN defined, a wait counter SHALL run in WAIT_ALLOC and READ (cleared per accepted beat); reaching TIMEOUT SHALL force command_in=000 and go to RESP with rsp_err=1.
REQ-022 Without SC_HOST_TIMEOUT_EN, WAIT_ALLOC and READ SHALL wait indefinitely and no timeout logic SHALL exist.

Verification
REQ-023 Op 010, size 3; model returns allocation_id=0 two cycles later -> one rsp_valid, rsp_data=0, rsp_err=0.
REQ-024 Op 101, id 0; model streams 16 beats of 4'b1010, last on beat 16 -> rsp_data=64'hAAAA_AAAA_AAAA_AAAA, command_in=101 for all beats then 000.
REQ-025 Op 101; model sends 3 beats 1,2,3 with last -> rsp_data=64'h321; model sends 17 beats -> rsp_err=1.
REQ-026 Op 100 with data 64'hAAAA_AAAA_AAAA_AAAA -> one cycle command_in=100, valid_load_data=1, rsp_valid next cycle; op 111 or req_id=10 -> rsp_err=1, command_in stays 000.
REQ-027 rst pulsed low during READ beat 5 -> all outputs 0, req_ready=1, no rsp_valid; with SC_HOST_TIMEOUT_EN and no reply -> rsp_err=1 after TIMEOUT cycles.
